// File: rtl/moxie_mem_arb_if.sv
// Bus bundle between the moxie pipeline requesters, the memory arbiter and the memory port.
// Signal suffixes (_i/_o) are named from the arbiter's point of view.
interface moxie_mem_arb_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  if_req_i;
  logic [ADDR_W-1:0]     if_addr_i;
  logic                  if_ack_o;
  logic [DATA_W-1:0]     if_rdata_o;

  logic                  d_req_i;
  logic                  d_we_i;
  logic [ADDR_W-1:0]     d_addr_i;
  logic [DATA_W-1:0]     d_wdata_i;
  logic [DATA_W/8-1:0]   d_sel_i;
  logic                  d_ack_o;
  logic [DATA_W-1:0]     d_rdata_o;

  logic                  mem_req_o;
  logic                  mem_we_o;
  logic [ADDR_W-1:0]     mem_addr_o;
  logic [DATA_W-1:0]     mem_wdata_o;
  logic [DATA_W/8-1:0]   mem_sel_o;
  logic                  mem_ack_i;
  logic [DATA_W-1:0]     mem_rdata_i;

  // Arbiter side
  modport slave (
    input  if_req_i, if_addr_i,
    output if_ack_o, if_rdata_o,
    input  d_req_i, d_we_i, d_addr_i, d_wdata_i, d_sel_i,
    output d_ack_o, d_rdata_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_sel_o,
    input  mem_ack_i, mem_rdata_i
  );

  // Pipeline requesters and memory model side
  modport master (
    output if_req_i, if_addr_i,
    input  if_ack_o, if_rdata_o,
    output d_req_i, d_we_i, d_addr_i, d_wdata_i, d_sel_i,
    input  d_ack_o, d_rdata_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_sel_o,
    output mem_ack_i, mem_rdata_i
  );
endinterface

// File: rtl/moxie_mem_arb.sv
// Two-requester arbiter (instruction fetch, data) onto the single moxie memory port.
// Data has priority; a starvation counter forces a fetch grant after STARVE_MAX data wins.
module moxie_mem_arb #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  moxie_mem_arb_if.slave    bus,
  output logic              owner_o,
  output logic              busy_o
);

  localparam int SEL_W = DATA_W / 8;
  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_GNT  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  starve_q, starve_d;
  logic              owner_q, owner_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [SEL_W-1:0]  mem_sel_q, mem_sel_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              fetch_win;

  function automatic logic fetch_wins(input logic ireq, input logic dreq,
                                      input logic [CNT_W-1:0] cnt);
    return ireq && (!dreq || (cnt == STARVE_LIM));
  endfunction

  // Starvation only accumulates while fetch is actually waiting behind data.
  function automatic logic [CNT_W-1:0] starve_after_data(input logic [CNT_W-1:0] cnt,
                                                         input logic ireq);
    if (!ireq)
      return '0;
    else if (cnt == STARVE_LIM)
      return cnt;
    else
      return cnt + CNT_W'(1);
  endfunction

  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    owner_d     = owner_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_sel_d   = mem_sel_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    fetch_win   = fetch_wins(bus.if_req_i, bus.d_req_i, starve_q);

    case (state_q)
      S_IDLE: begin
        if (bus.if_req_i || bus.d_req_i) begin
          state_d = S_GNT;
          owner_d = !fetch_win;
          if (fetch_win) begin
            starve_d    = '0;
            mem_we_d    = 1'b0;
            mem_addr_d  = bus.if_addr_i;
            mem_wdata_d = '0;
            mem_sel_d   = '1;
          end else begin
            starve_d    = starve_after_data(starve_q, bus.if_req_i);
            mem_we_d    = bus.d_we_i;
            mem_addr_d  = bus.d_addr_i;
            mem_wdata_d = bus.d_wdata_i;
            mem_sel_d   = bus.d_sel_i;
          end
        end
      end
      S_GNT: begin
        if (bus.mem_ack_i) begin
          state_d = S_RESP;
          if (!mem_we_q) begin
            if (owner_q)
              d_rdata_d = bus.mem_rdata_i;
            else
              if_rdata_d = bus.mem_rdata_i;
          end
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      starve_q    <= '0;
      owner_q     <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_sel_q   <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      owner_q     <= owner_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_sel_q   <= mem_sel_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  // Handshake outputs decode straight from state so reset clears them asynchronously.
  assign bus.mem_req_o   = (state_q == S_GNT);
  assign bus.mem_we_o    = mem_we_q;
  assign bus.mem_addr_o  = mem_addr_q;
  assign bus.mem_wdata_o = mem_wdata_q;
  assign bus.mem_sel_o   = mem_sel_q;
  assign bus.if_ack_o    = (state_q == S_RESP) && !owner_q;
  assign bus.d_ack_o     = (state_q == S_RESP) &&  owner_q;
  assign bus.if_rdata_o  = if_rdata_q;
  assign bus.d_rdata_o   = d_rdata_q;
  assign owner_o         = owner_q;
  assign busy_o          = (state_q == S_GNT) || (state_q == S_RESP);

endmodule

// File: doc/moxie_mem_arb.md
Name: moxie_mem_arb

Overview:
- Two-requester arbiter sharing the core's single 32-bit memory port.
- Requester 1 is instruction fetch, which fills the 64-bit instruction buffer one 32-bit word per request.
- Requester 2 is data (load/store from the execute stage).
- Data normally has priority; a starvation counter guarantees fetch progress. Sits between the pipeline and the memory/bus interface.

Parameters:
- ADDR_W, 32, address width of all address ports
- DATA_W, 32, data width; byte-select width is DATA_W/8
- STARVE_MAX, 4, max consecutive data grants while fetch is waiting before fetch is forced

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- if_req_i  in  1  fetch request, held until if_ack_o
- if_addr_i  in  ADDR_W  fetch word address, stable while if_req_i
- if_ack_o  out  1  one-cycle fetch completion pulse
- if_rdata_o  out  DATA_W  fetched word, valid with if_ack_o, held after
- d_req_i  in  1  data request, held until d_ack_o
- d_we_i  in  1  1=store, 0=load
- d_addr_i  in  ADDR_W  data address
- d_wdata_i  in  DATA_W  store data
- d_sel_i  in  DATA_W/8  byte enables (.b/.s/.l)
- d_ack_o  out  1  one-cycle data completion pulse
- d_rdata_o  out  DATA_W  load data, valid with d_ack_o, held after
- mem_req_o  out  1  memory cycle request
- mem_we_o  out  1  memory write enable
- mem_addr_o  out  ADDR_W  memory address
- mem_wdata_o  out  DATA_W  memory write data
- mem_sel_o  out  DATA_W/8  byte enables; all ones for fetch
- mem_ack_i  in  1  memory completion, any latency >= 0 cycles after mem_req_o rises
- mem_rdata_i  in  DATA_W  read data, valid with mem_ack_i
- owner_o  out  1  0=fetch, 1=data; meaningful while busy_o
- busy_o  out  1  1 in GNT or RESP

Behaviour:
- Reset (reset=0, async):
  - state=IDLE; starve counter=0.
  - All outputs 0, including both rdata registers.
  - Any in-flight memory cycle is abandoned; no ack is issued for it.
- States:
  - IDLE: sample requests and pick a winner. Register owner, addr, we, wdata and sel into the mem_* outputs. Go to GNT. Stay in IDLE if there is no request.
  - GNT: mem_req_o=1 with stable mem_* outputs.
    - On mem_ack_i=1: capture mem_rdata_i into the owner's rdata register (reads only), drop mem_req_o next cycle, go to RESP.
    - Otherwise stay in GNT.
  - RESP: owner's ack_o=1 for exactly this cycle, then go to IDLE.
- Latency with zero-wait memory:
  - Request seen in cycle 0 -> mem_req_o in cycle 1 -> ack_o in cycle 2 -> next arbitration in cycle 3.
  - Back-to-back throughput is one transfer per 3 cycles.
- Arbitration when both requests are present in IDLE:
  - Data wins unless starve_cnt==STARVE_MAX; in that case fetch wins.
  - starve_cnt increments (saturating at STARVE_MAX) on each data grant made while if_req_i=1.
  - starve_cnt clears on any fetch grant, and on a data grant with if_req_i=0.
- Fetch is always a read: mem_we_o=0 and mem_sel_o=all ones.
- Store: mem_we_o=1; d_rdata_o is not updated; d_ack_o still pulses.
- mem_ack_i in IDLE or RESP is ignored.
- If a requester withdraws req during GNT, the cycle still completes and the ack pulse is still issued. This is a protocol violation and the requester must ignore the pulse.
- owner_o and the mem_* outputs change only on the IDLE->GNT transition.

Test Plan:
- Fetch only, addr 0x1000, mem_ack_i in the first GNT cycle, rdata 0x12345678 -> mem_req_o high exactly cycle 1; if_ack_o pulse in cycle 2; if_rdata_o=0x12345678 held afterwards.
- Store addr 0x2004, wdata 0xDEADBEEF, sel 4'b0011, memory waits 3 cycles -> mem_we_o=1 and mem_sel_o=0011 for 4 GNT cycles; d_ack_o one pulse; d_rdata_o unchanged.
- Both requests held continuously, STARVE_MAX=4 -> grant order D,D,D,D,I,D,D,D,D,I; owner_o matches each grant.
- Simultaneous requests with starve_cnt=0 -> data wins; fetch is granted in the IDLE after data's RESP.
- reset=0 asserted mid-GNT with mem_req_o high -> mem_req_o, busy_o and acks go 0 immediately (asynchronous); after release, a fetch request completes normally.
- mem_ack_i pulsed while IDLE -> no ack_o pulse, no rdata change, state stays IDLE.
